gpr: RTL and testbench



---
 rtl/gpr.sv | 63 ++++++
 tb/tb_gpr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr.sv
// gpr: 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports (rs -> busa, rt -> busb) and one write port
// that commits on the rising edge of clk. Register 0 is hardwired to zero.
// Reset is asynchronous and active-high and clears every register at once.
// There is no write-to-read bypass: a read of the register being written
// returns the old contents until the clock edge commits the new value.
module gpr (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite,
  input  logic [4:0]  m1out,
  input  logic [31:0] m2out,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic [31:0] busa,
  output logic [31:0] busb
);

  // Register storage. Entry 0 is carried for regular indexing but is
  // forced to zero on every path and is never selected by the read ports.
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // True when this cycle's write targets a real (nonzero) register.
  logic write_en;

  // Decide whether the incoming write is allowed to land.
  always_comb begin
    write_en = regwrite && (m1out != 5'd0);
  end

  // Next-state of the array: hold everything, then overlay the one write.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_en) begin
      regs_d[m1out] = m2out;
    end
    regs_d[0] = 32'h0000_0000;
  end

  // Commit writes on the rising edge; reset clears immediately and wins
  // over any edge that coincides with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational reads; address 0 is decoded to a constant zero.
  always_comb begin
    busa = (rs == 5'd0) ? 32'h0000_0000 : regs_q[rs];
    busb = (rt == 5'd0) ? 32'h0000_0000 : regs_q[rt];
  end

endmodule

// File: tb/tb_gpr.sv
// tb_gpr: directed bench for the gpr register file. A table of vectors
// covers the full address range and dual-port reads; hand-written
// sequences cover reset, r0, write enable, back-to-back writes and the
// asynchronous reset corner cases.
module tb_gpr;

  logic        clk;
  logic        reset;
  logic        regwrite;
  logic [4:0]  m1out;
  logic [31:0] m2out;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] busa;
  logic [31:0] busb;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs[$];

  gpr dut (
    .clk      (clk),
    .reset    (reset),
    .regwrite (regwrite),
    .m1out    (m1out),
    .m2out    (m2out),
    .rs       (rs),
    .rt       (rt),
    .busa     (busa),
    .busb     (busb)
  );

  // Clock starts high, period 60: rising edges at 60, 120, ...
  initial begin
    clk = 1'b1;
    forever #30 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Contents expected after the full-range write phase.
  function automatic logic [31:0] fill_val(input int i);
    return (i == 0) ? 32'h0 : (32'h100 + 32'(i));
  endfunction

  initial begin
    vec_t v;
    reset    = 1'b0;
    regwrite = 1'b0;
    m1out    = 5'd0;
    m2out    = 32'h0;
    rs       = 5'd0;
    rt       = 5'd1;

    // Reset clear: pulse from t=5 to t=10.
    #5 reset = 1'b1;
    #1;
    check("reset_during_a", busa, 32'h0);
    check("reset_during_b", busb, 32'h0);
    #4 reset = 1'b0;
    #1;
    check("reset_after_a", busa, 32'h0);
    check("reset_after_b", busb, 32'h0);

    // Write to r0 is discarded (driven t=30, edge at 60).
    @(negedge clk);
    m1out    = 5'd0;
    m2out    = 32'habcd_ef12;
    regwrite = 1'b1;
    rs       = 5'd0;
    #1;
    check("r0_pre_edge", busa, 32'h0);
    @(posedge clk);
    #1;
    check("r0_post_edge", busa, 32'h0);

    // Normal write of r1, read on port B.
    m1out = 5'd1;
    rt    = 5'd1;
    #1;
    check("r1_pre_edge_b", busb, 32'h0);
    @(posedge clk);
    #1;
    check("r1_post_edge_b", busb, 32'habcd_ef12);
    check("r1_post_edge_a_r0", busa, 32'h0);

    // Write disabled across several edges.
    regwrite = 1'b0;
    m1out    = 5'd5;
    m2out    = 32'h1234_5678;
    rs       = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check("we_off_r5", busa, 32'h0);

    // Table: write r1..r31 with 0x100+i. Port A reads the register being
    // written (old value before the edge); port B reads the one written on
    // the previous edge.
    for (int i = 1; i < 32; i++) begin
      v.we = 1'b1;
      v.wa = 5'(i);
      v.wd = 32'h100 + 32'(i);
      v.ra = 5'(i);
      v.rb = 5'(i - 1);
      v.ea = (i == 1) ? 32'habcd_ef12 : 32'h0;
      v.eb = (i == 1) ? 32'h0 : fill_val(i - 1);
      vecs.push_back(v);
    end
    // Sweep with writes disabled but address/data toggling.
    for (int i = 0; i < 32; i++) begin
      v.we = 1'b0;
      v.wa = 5'(i);
      v.wd = 32'hffff_ffff;
      v.ra = 5'(i);
      v.rb = 5'(31 - i);
      v.ea = fill_val(i);
      v.eb = fill_val(31 - i);
      vecs.push_back(v);
      v.rb = 5'(i);
      v.eb = fill_val(i);
      vecs.push_back(v);
    end

    foreach (vecs[k]) begin
      @(negedge clk);
      regwrite = vecs[k].we;
      m1out    = vecs[k].wa;
      m2out    = vecs[k].wd;
      rs       = vecs[k].ra;
      rt       = vecs[k].rb;
      #1;
      check($sformatf("vec%0d_a", k), busa, vecs[k].ea);
      check($sformatf("vec%0d_b", k), busb, vecs[k].eb);
    end

    // Back-to-back writes to the same register: last write wins.
    @(negedge clk);
    regwrite = 1'b1;
    m1out    = 5'd3;
    m2out    = 32'h0000_aaaa;
    @(negedge clk);
    m2out    = 32'h0000_bbbb;
    @(negedge clk);
    regwrite = 1'b0;
    rs       = 5'd3;
    #1;
    check("b2b_last_wins", busa, 32'h0000_bbbb);

    // Asynchronous reset mid-cycle.
    rs = 5'd31;
    rt = 5'd30;
    #1;
    check("pre_async_a", busa, 32'h0000_011f);
    check("pre_async_b", busb, 32'h0000_011e);
    #10 reset = 1'b1;
    #1;
    check("async_clear_a", busa, 32'h0);
    check("async_clear_b", busb, 32'h0);

    // Write attempted on an edge while reset is held.
    regwrite = 1'b1;
    m1out    = 5'd7;
    m2out    = 32'h0000_0077;
    rs       = 5'd7;
    rt       = 5'd31;
    @(posedge clk);
    #1;
    check("write_in_reset", busa, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_deassert_r7", busa, 32'h0);
    check("after_deassert_r31", busb, 32'h0);

    // First edge after deassertion performs the write.
    @(posedge clk);
    #1;
    check("first_write_after_reset", busa, 32'h0000_0077);
    regwrite = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
